// File: rtl/instr_fetch.sv
// instr_fetch: program counter plus a single-outstanding instruction fetch
// engine in front of a fixed-latency instruction RAM.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   load_pc, sel_pc   PC update strobe and source (00 +1, 01 start, 10 branch, 11 hold)
//   start_pc          boot address
//   branch_addr       branch target
//   fetch_req         fetch the instruction at the current pc (taken in IDLE only)
//   flush             abort an outstanding fetch and invalidate instr
//   ram_rd_data       instruction RAM read data
//   ram_addr          instruction RAM read address
//   pc, pc_read       program counter and pc+2 (PC-relative operand base)
//   instr             captured instruction
//   instr_valid       instr holds a completed, unflushed fetch
//   busy              fetch outstanding (WAIT)
//   fetch_done        one-cycle pulse in the cycle after capture
//   fetch_count       completed fetches, saturating at 16'hFFFF
module instr_fetch #(
  parameter int RAM_LATENCY = 2,
  parameter int ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_pc,
  input  logic [1:0]        sel_pc,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              fetch_req,
  input  logic              flush,
  input  logic [31:0]       ram_rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_read,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              busy,
  output logic              fetch_done,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  // Wait counter is loaded with latency-1 so capture lands on edge N+RAM_LATENCY.
  localparam logic [3:0] CNT_INIT = 4'(RAM_LATENCY - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] fetch_addr;
  logic [15:0]       fetch_count_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush overrides everything, including a new request
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (fetch_req) state_nxt = WAIT;
        WAIT:    if (cnt == 4'd0) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy       = (state == WAIT);
    fetch_done = (state == DONE);
    ram_addr   = (state == WAIT) ? fetch_addr : pc;
  end

  // Datapath: pc updates independently of the fetch engine, so a branch
  // taken in WAIT never disturbs the in-flight address (fetch_addr).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= '0;
      fetch_addr    <= '0;
      cnt           <= '0;
      instr         <= '0;
      instr_valid   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      if (load_pc) begin
        case (sel_pc)
          2'b00:   pc <= pc + ADDR_W'(1);
          2'b01:   pc <= start_pc;
          2'b10:   pc <= branch_addr;
          default: pc <= pc;
        endcase
      end
      if (flush) instr_valid <= 1'b0;
      else begin
        case (state)
          IDLE: if (fetch_req) begin
            fetch_addr  <= pc;          // pre-update pc if load_pc is also high
            cnt         <= CNT_INIT;
            instr_valid <= 1'b0;
          end
          WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            instr       <= ram_rd_data;
            instr_valid <= 1'b1;
            if (fetch_count_q != 16'hFFFF) fetch_count_q <= fetch_count_q + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign pc_read     = pc + ADDR_W'(2);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_pc = 1'b0, fetch_req = 1'b0, flush = 1'b0;
  logic [1:0]    sel_pc = 2'b11;
  logic [AW-1:0] start_pc = '0, branch_addr = '0;

  // d2: default build (RAM_LATENCY=2); d1: RAM_LATENCY=1 build
  logic [AW-1:0] ram_addr2, pc2, pc_read2, ram_addr1, pc1, pc_read1;
  logic [31:0]   rd2, rd1, instr2, instr1;
  logic          iv2, busy2, fd2, iv1, busy1, fd1;
  logic [15:0]   cnt2, cnt1;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    if (a == 11'h040) return 32'hE3A01005;
    return 32'hC0DE0000 | {21'd0, a};
  endfunction

  assign rd2 = mem(ram_addr2);
  assign rd1 = mem(ram_addr1);

  instr_fetch #(.RAM_LATENCY(2), .ADDR_W(AW)) u_d2 (
    .clk(clk), .rst(rst), .load_pc(load_pc), .sel_pc(sel_pc), .start_pc(start_pc),
    .branch_addr(branch_addr), .fetch_req(fetch_req), .flush(flush), .ram_rd_data(rd2),
    .ram_addr(ram_addr2), .pc(pc2), .pc_read(pc_read2), .instr(instr2), .instr_valid(iv2),
    .busy(busy2), .fetch_done(fd2), .fetch_count(cnt2));

  instr_fetch #(.RAM_LATENCY(1), .ADDR_W(AW)) u_d1 (
    .clk(clk), .rst(rst), .load_pc(load_pc), .sel_pc(sel_pc), .start_pc(start_pc),
    .branch_addr(branch_addr), .fetch_req(fetch_req), .flush(flush), .ram_rd_data(rd1),
    .ram_addr(ram_addr1), .pc(pc1), .pc_read(pc_read1), .instr(instr1), .instr_valid(iv1),
    .busy(busy1), .fetch_done(fd1), .fetch_count(cnt1));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [AW-1:0] br);
    load_pc = 1'b1; sel_pc = sel; branch_addr = br;
    tick();
    load_pc = 1'b0;
  endtask

  // Pulse fetch_req at current pc, check capture on edge N+2 for d2
  task automatic fetch2(input logic [31:0] exp_instr, input logic [15:0] exp_cnt);
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;       // edge N
    chk("f_busy_N", busy2, 1);
    tick();                                             // edge N+1
    chk("f_iv_N1", iv2, 0);
    chk("f_busy_N1", busy2, 1);
    tick();                                             // edge N+2
    chk("f_instr", instr2, exp_instr);
    chk("f_iv", iv2, 1);
    chk("f_done", fd2, 1);
    chk("f_cnt", cnt2, exp_cnt);
    tick();
    chk("f_done_off", fd2, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    tick();
    chk("rst_pc", pc2, 0);       chk("rst_instr", instr2, 0);
    chk("rst_iv", iv2, 0);       chk("rst_busy", busy2, 0);
    chk("rst_done", fd2, 0);     chk("rst_cnt", cnt2, 0);
    chk("rst_ramaddr", ram_addr2, 0);
    chk("rst_pcread", pc_read2, 11'h002);
    rst = 1'b0;
    tick();

    // Boot
    start_pc = 11'h040;
    load(2'b01, 11'h000);
    chk("boot_pc", pc2, 11'h040);
    chk("boot_ramaddr", ram_addr2, 11'h040);
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    chk("boot_busy", busy2, 1);
    chk("boot_ramaddr_w", ram_addr2, 11'h040);
    tick();
    chk("boot_iv_n1", iv2, 0);
    tick();
    chk("boot_instr", instr2, 32'hE3A01005);
    chk("boot_done", fd2, 1);
    chk("boot_cnt", cnt2, 1);
    tick();
    chk("boot_done_off", fd2, 0);
    chk("boot_iv_hold", iv2, 1);

    // Sequential loop
    for (int i = 1; i <= 3; i++) begin
      load(2'b00, 11'h000);
      chk("seq_pc", pc2, 32'h40 + i);
      chk("seq_pcread", pc_read2, 32'h42 + i);
      fetch2(32'hC0DE0040 + i, 16'(1 + i));
    end

    // Wrap
    load(2'b10, 11'h7FF);
    chk("wrap_pcread", pc_read2, 11'h001);
    load(2'b00, 11'h000);
    chk("wrap_pc", pc2, 11'h000);
    chk("wrap_pcread0", pc_read2, 11'h002);

    // Branch mid-fetch
    load(2'b10, 11'h010);
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    load(2'b10, 11'h200);
    chk("br_pc", pc2, 11'h200);
    chk("br_ramaddr", ram_addr2, 11'h010);
    tick();
    chk("br_instr", instr2, 32'hC0DE0010);
    chk("br_cnt", cnt2, 5);
    tick();

    // load_pc and fetch_req together in IDLE: fetch uses old pc
    load_pc = 1'b1; sel_pc = 2'b00; fetch_req = 1'b1;
    tick();
    load_pc = 1'b0; fetch_req = 1'b0;
    chk("same_pc", pc2, 11'h201);
    chk("same_ramaddr", ram_addr2, 11'h200);
    tick(); tick();
    chk("same_instr", instr2, 32'hC0DE0200);
    chk("same_cnt", cnt2, 6);
    tick();

    // Flush during WAIT
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_busy", busy2, 0);
    chk("fl_iv", iv2, 0);
    chk("fl_instr", instr2, 32'hC0DE0200);
    tick(); tick();
    chk("fl_done", fd2, 0);
    chk("fl_cnt", cnt2, 6);

    // Flush with fetch_req (and load_pc) in IDLE
    flush = 1'b1; fetch_req = 1'b1; load_pc = 1'b1; sel_pc = 2'b00;
    tick();
    flush = 1'b0; fetch_req = 1'b0; load_pc = 1'b0;
    chk("flr_busy", busy2, 0);
    chk("flr_pc", pc2, 11'h202);
    tick();
    chk("flr_busy2", busy2, 0);

    // fetch_req held high: one capture per IDLE acceptance
    fetch_req = 1'b1;
    tick(); tick(); tick();
    chk("hold_done", fd2, 1);
    chk("hold_cnt", cnt2, 7);
    tick();
    chk("hold_idle", busy2, 0);
    chk("hold_cnt2", cnt2, 7);
    tick();
    chk("hold_accept", busy2, 1);
    fetch_req = 1'b0;
    tick(); tick();
    chk("hold_cnt3", cnt2, 8);
    chk("hold_instr", instr2, 32'hC0DE0202);
    tick();

    // Reset mid-WAIT
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    tick();
    rst = 1'b1; #1;
    chk("mrst_pc", pc2, 0);      chk("mrst_instr", instr2, 0);
    chk("mrst_iv", iv2, 0);      chk("mrst_busy", busy2, 0);
    chk("mrst_done", fd2, 0);    chk("mrst_cnt", cnt2, 0);
    chk("mrst_ramaddr", ram_addr2, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_nodone", fd2, 0);
    end
    chk("mrst_iv_after", iv2, 0);

    // RAM_LATENCY=1 build with saturated counter
    start_pc = 11'h040;
    load(2'b01, 11'h000);
    force u_d1.fetch_count_q = 16'hFFFF;
    #1;
    release u_d1.fetch_count_q;
    chk("l1_forced", cnt1, 16'hFFFF);
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    chk("l1_busy", busy1, 1);
    tick();
    chk("l1_instr", instr1, 32'hE3A01005);
    chk("l1_iv", iv1, 1);
    chk("l1_done", fd1, 1);
    chk("l1_sat", cnt1, 16'hFFFF);
    chk("l1_vs_l2_iv", iv2, 0);
    tick();
    chk("l1_done_off", fd1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RAM_LATENCY, default 2, meaning clock edges from fetch acceptance to instruction capture; legal range 1..15.
REQ-002 Parameter ADDR_W, default 11, meaning word-address width of PC and instruction RAM.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 load_pc  in  1  PC update strobe from controller.
REQ-006 sel_pc  in  2  PC source select: 00 PC+1, 01 start_pc, 10 branch_addr, 11 hold.
REQ-007 start_pc  in  ADDR_W  boot address.
REQ-008 branch_addr  in  ADDR_W  branch target.
REQ-009 fetch_req  in  1  request to fetch the instruction at current PC.
REQ-010 flush  in  1  abort any outstanding fetch and invalidate instr.
REQ-011 ram_rd_data  in  32  instruction RAM read data.
REQ-012 ram_addr  out  ADDR_W  instruction RAM read address.
REQ-013 pc  out  ADDR_W  current program counter.
REQ-014 pc_read  out  ADDR_W  PC+2 modulo 2^ADDR_W, for PC-relative operands.
REQ-015 instr  out  32  captured instruction, registered.
REQ-016 instr_valid  out  1  instr holds a completed, unflushed fetch.
REQ-017 busy  out  1  high while a fetch is outstanding.
REQ-018 fetch_done  out  1  one-cycle pulse following capture.
REQ-019 fetch_count  out  16  number of completed fetches, saturating.

Function
REQ-020 FSM states SHALL be IDLE, WAIT, DONE; reset state IDLE.
REQ-021 IDLE: fetch_req=1 and flush=0 at an edge SHALL latch fetch_addr<=pc, cnt<=RAM_LATENCY-1, clear instr_valid, go to WAIT.
REQ-022 WAIT: at an edge with cnt!=0, cnt SHALL decrement; with cnt==0, instr<=ram_rd_data, instr_valid<=1, fetch_count increments, go to DONE.
REQ-023 DONE SHALL assert fetch_done for exactly that cycle and return to IDLE at the next edge.
REQ-024 Capture SHALL occur at edge N+RAM_LATENCY, where edge N accepted fetch_req.
REQ-025 ram_addr SHALL equal fetch_addr in WAIT, and pc in IDLE and DONE.
REQ-026 busy SHALL be 1 exactly in WAIT.
REQ-027 fetch_req outside IDLE SHALL be ignored, with no queuing.
REQ-028 load_pc=1 at an edge SHALL update pc per sel_pc in any state: 00 pc+1, 01 start_pc, 10 branch_addr, 11 unchanged.
REQ-029 PC+1 SHALL wrap from 2^ADDR_W-1 to 0; pc_read SHALL wrap likewise.
REQ-030 load_pc during WAIT SHALL NOT alter fetch_addr or the in-flight capture.
REQ-031 load_pc and fetch_req in the same IDLE cycle: the fetch SHALL use the pre-update pc.
REQ-032 flush=1 at an edge SHALL force IDLE, clear instr_valid, suppress capture, fetch_done and count increment, and leave instr unchanged.
REQ-033 flush and fetch_req together SHALL resolve as flush only; no fetch starts.
REQ-034 flush SHALL NOT affect pc; load_pc in the same cycle still applies.
REQ-035 fetch_count SHALL saturate at 16'hFFFF.

Reset
REQ-036 rst=1 SHALL immediately force: state IDLE, pc 0, fetch_addr 0, cnt 0, instr 0, instr_valid 0, fetch_done 0, busy 0, fetch_count 0.
REQ-037 rst asserted mid-WAIT SHALL discard the fetch; no capture after release.
REQ-038 The first edge after rst deasserts SHALL be a normal IDLE edge.

Verification
REQ-039 Boot: release rst, load_pc=1, sel_pc=01, start_pc=0x040, then fetch_req pulse with RAM[0x040]=0xE3A01005 -> pc=0x040, ram_addr=0x040, instr=0xE3A01005 at edge N+2, fetch_done one cycle, fetch_count=1.
REQ-040 Sequential loop: three rounds of load_pc/sel_pc=00 followed by a fetch -> pc goes 0x041, 0x042, 0x043, each capture at N+2, pc_read=pc+2; pc=0x7FF with sel_pc=00 -> pc=0x000, pc_read wraps 0x7FF->0x001.
REQ-041 Branch mid-fetch: fetch at pc=0x010, load_pc sel_pc=10 branch_addr=0x200 in WAIT -> instr is RAM[0x010], then pc=0x200.
REQ-042 Flush: flush during WAIT -> no capture, instr_valid=0, busy=0, fetch_count unchanged; flush with fetch_req in IDLE -> stays IDLE.
REQ-043 Ignored request and reset: fetch_req held high through WAIT and DONE -> exactly one capture per IDLE acceptance; rst pulse mid-WAIT -> all outputs zero, no later fetch_done.
REQ-044 RAM_LATENCY=1 build: capture at edge N+1; fetch_count saturation checked by forcing 0xFFFF and completing one fetch -> stays 0xFFFF.
